// File: rtl/spi_slave_core.sv
// SPI responder core: oversamples SCLK/SS_N/MOSI in the clk domain and exchanges one byte
// per eight SCLK cycles in any CPOL/CPHA mode, with one-byte RX/TX buffers and an RX interrupt.
module spi_slave_core #(
    parameter int SYNC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        spi_sclk,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq
);

    logic [SYNC-1:0] sclk_sync_p, ss_sync_p, mosi_sync_p;
    logic            sclk_prev, ss_prev;
    logic            sclk_sync, ss_sync, mosi_sync;

    logic       cpol, cpha, irq_en;
    logic [7:0] rx_data, rx_sreg, tx_buf, tx_sreg;
    logic       rx_valid, rx_ovr, tx_udr, tx_full, pending_load;
    logic [2:0] bit_cnt;

    logic wr_en, pop;
    logic rise, fall, sample_edge, shift_edge;
    logic ss_fall, ss_rise, complete, do_load;

    assign sclk_sync = sclk_sync_p[SYNC-1];
    assign ss_sync   = ss_sync_p[SYNC-1];
    assign mosi_sync = mosi_sync_p[SYNC-1];

    // Input synchronizers; ss_n idles high so the core starts deselected
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_p <= '0;
            ss_sync_p   <= '1;
            mosi_sync_p <= '0;
            sclk_prev   <= 1'b0;
            ss_prev     <= 1'b1;
        end else begin
            sclk_sync_p <= {sclk_sync_p[SYNC-2:0], spi_sclk};
            ss_sync_p   <= {ss_sync_p[SYNC-2:0], spi_ss_n};
            mosi_sync_p <= {mosi_sync_p[SYNC-2:0], spi_mosi};
            sclk_prev   <= sclk_sync;
            ss_prev     <= ss_sync;
        end
    end

    assign wr_en = cs & write;
    assign pop   = cs & read & (addr[1:0] == 2'b00);

    assign rise        = sclk_sync & ~sclk_prev & ~ss_sync;
    assign fall        = ~sclk_sync & sclk_prev & ~ss_sync;
    assign sample_edge = (cpol == cpha) ? rise : fall;
    assign shift_edge  = (cpol == cpha) ? fall : rise;
    assign ss_fall     = ss_prev & ~ss_sync;
    assign ss_rise     = ~ss_prev & ss_sync;
    assign complete    = sample_edge & (bit_cnt == 3'd7);
    // cpha=0 presents the MSB at select; cpha=1 defers the load to the first shift edge
    assign do_load     = (ss_fall & ~cpha) | (shift_edge & pending_load & ~ss_fall & ~ss_rise);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpol         <= 1'b0;
            cpha         <= 1'b0;
            irq_en       <= 1'b0;
            rx_data      <= 8'h00;
            rx_sreg      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_ovr       <= 1'b0;
            tx_udr       <= 1'b0;
            tx_full      <= 1'b0;
            tx_buf       <= 8'h00;
            tx_sreg      <= 8'h00;
            bit_cnt      <= 3'd0;
            pending_load <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (wr_en && addr[1:0] == 2'b10) begin
                cpol   <= wr_data[0];
                cpha   <= wr_data[1];
                irq_en <= wr_data[2];
            end
            if (wr_en && addr[1:0] == 2'b11) begin
                rx_ovr <= 1'b0;
                tx_udr <= 1'b0;
            end

            if (ss_fall) begin
                bit_cnt      <= 3'd0;
                pending_load <= cpha;
            end else if (ss_rise) begin
                bit_cnt      <= 3'd0;
                pending_load <= 1'b0;
            end else begin
                if (sample_edge) begin
                    rx_sreg <= {rx_sreg[6:0], mosi_sync};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (complete)
                        pending_load <= 1'b1;
                end
                if (shift_edge) begin
                    if (pending_load)
                        pending_load <= 1'b0;
                    else
                        tx_sreg <= {tx_sreg[6:0], 1'b0};
                end
            end

            // An empty buffer at load time shifts out zeros and flags underrun
            if (do_load) begin
                if (tx_full) begin
                    tx_sreg <= tx_buf;
                    tx_full <= 1'b0;
                end else begin
                    tx_sreg <= 8'h00;
                    tx_udr  <= 1'b1;
                end
            end
            if (wr_en && addr[1:0] == 2'b01) begin
                tx_buf  <= wr_data[7:0];
                tx_full <= 1'b1;
            end

            if (complete && !ss_fall && !ss_rise) begin
                rx_data  <= {rx_sreg[6:0], mosi_sync};
                rx_valid <= 1'b1;
                if (rx_valid && !pop)
                    rx_ovr <= 1'b1;
            end else if (pop) begin
                rx_valid <= 1'b0;
            end

            irq <= irq_en & rx_valid;
        end
    end

    assign spi_miso    = ~ss_sync & tx_sreg[7];
    assign spi_miso_oe = ~ss_sync;

    always_comb begin
        rd_data = 32'h0;
        case (addr[1:0])
            2'b00:   rd_data = {22'b0, rx_ovr, rx_valid, rx_data};
            2'b01:   rd_data = {30'b0, tx_udr, tx_full};
            2'b10:   rd_data = {29'b0, irq_en, cpha, cpol};
            default: rd_data = {31'b0, ~ss_sync};
        endcase
    end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Memory-mapped SPI responder (slave) core for the processor's I/O slot bus. It lets the SoC sit on the far end of an external SPI link that another device masters. The core oversamples the external SCLK/SS_N/MOSI in the `clk` domain, shifts bytes in on MOSI and out on MISO in any of the four CPOL/CPHA modes, and buffers one received and one transmit byte with status flags and an interrupt.

## Interface
- `SYNC` — default 2; number of synchronizer flops on `spi_sclk`, `spi_ss_n` and `spi_mosi`, minimum 2.
- `clk` — in, 1 — system clock.
- `reset` — in, 1 — reset, asynchronous, active-high.
- `cs` — in, 1 — slot select.
- `read` — in, 1 — read strobe; a read of addr 00 pops RX.
- `write` — in, 1 — write strobe.
- `addr` — in, 5 — register address; only `addr[1:0]` is decoded.
- `wr_data` — in, 32 — write data.
- `rd_data` — out, 32 — combinational read mux on `addr[1:0]`.
- `spi_sclk` — in, 1 — external serial clock.
- `spi_ss_n` — in, 1 — external select, active-low.
- `spi_mosi` — in, 1 — serial data in.
- `spi_miso` — out, 1 — serial data out; MSB first.
- `spi_miso_oe` — out, 1 — MISO tri-state enable; high while selected.
- `irq` — out, 1 — registered `irq_en & rx_valid`.

## Operation
Register writes (`wr_en = cs & write`):
- 01: `tx_buf <= wr_data[7:0]`, `tx_full <= 1`. A write while `tx_full` is set overwrites the buffer.
- 10: `cpol <= wr_data[0]`, `cpha <= wr_data[1]`, `irq_en <= wr_data[2]`. Software changes mode only while `spi_ss_n` is high.
- 11: any write clears `rx_ovr` and `tx_udr`.

Read mux:
- 00: `{22'b0, rx_ovr, rx_valid, rx_data}`. When `cs & read` is high, `rx_valid` clears on the next clock.
- 01: `{30'b0, tx_udr, tx_full}`.
- 10: `{29'b0, irq_en, cpha, cpol}`.
- 11: `{31'b0, active}`, where `active = ~ss_sync`.

Front end:
- `SYNC`-flop synchronizers on all three inputs, plus one extra flop on sclk for edge detect.
- Sample edge: rising when `cpol == cpha`, falling otherwise. Shift edge is the opposite polarity.
- All sclk edges are ignored while `ss_sync` is 1.

Select assertion (`ss_sync` 1→0):
- `bit_cnt <= 0`.
- cpha=0: `tx_sreg` loads immediately.
- cpha=1: set `pending_load`; the first shift edge loads instead of shifting.

Sample edge:
- `rx_sreg <= {rx_sreg[6:0], mosi_sync}` and `bit_cnt++`.
- On the 8th sample, `bit_cnt` wraps to 0 and `rx_data <= {rx_sreg[6:0], mosi_sync}`, `rx_valid <= 1`, `pending_load <= 1`.
- If `rx_valid` was already 1 and no pop occurs in the same cycle, set `rx_ovr`; the new byte still overwrites `rx_data`.
- Pop and completion in the same cycle: the new byte wins, `rx_valid` stays 1, no overrun.

Shift edge:
- If `pending_load`: load `tx_sreg` and clear `pending_load`.
- Otherwise: `tx_sreg <= {tx_sreg[6:0], 1'b0}`.

Load:
- If `tx_full`: `tx_sreg <= tx_buf`, `tx_full <= 0`.
- If not: `tx_sreg <= 8'h00`, set sticky `tx_udr`.
- A CPU write to 01 in the same cycle as a load goes to `tx_buf` after the load: `tx_full` ends at 1.

Outputs:
- `spi_miso = ~ss_sync & tx_sreg[7]`.
- `spi_miso_oe = ~ss_sync`.

Select deassertion mid-byte (`ss_sync` 0→1):
- Partial RX byte discarded; `bit_cnt <= 0`, `pending_load <= 0`.
- The partially shifted TX byte is lost; `tx_buf`/`tx_full` are unchanged.

## Timing
Reset values:
- Control and data: `cpol`, `cpha`, `irq_en`, `rx_data`, `rx_valid`, `rx_ovr`, `tx_udr`, `tx_full`, `tx_buf`, `tx_sreg`, `bit_cnt`, `pending_load` all 0.
- Synchronizers: sclk flops 0, ss_n flops 1, mosi flops 0.
- Outputs: `spi_miso` 0, `spi_miso_oe` 0, `irq` 0, `rd_data` 0 for every address.

Latencies:
- Pin to detected edge: `SYNC+1` clk. MISO updates on that same clk edge.
- `rx_valid` rises on the clk edge where the 8th sample edge is detected; `irq` follows 1 clk later.
- `rx_valid` clears 1 clk after the pop read; `irq` drops 1 clk after that.
- Register writes take effect on the next clk edge.

Constraint: each SCLK high and low phase is at least `SYNC+2` clk periods. The SS_N fall to first SCLK edge is also at least `SYNC+2` clk periods. Behaviour outside these limits is undefined.

## Test plan
- Mode 0, `tx_buf = 8'hA5`, master sends `8'h3C`: MISO bits are 1,0,1,0,0,1,0,1; `rx_data = 8'h3C`; `rx_valid = 1`; `tx_full = 0`; `irq = 1` when `irq_en = 1`.
- Modes 1, 2, 3, each with `tx_buf = 8'h81` and MOSI `8'h7E`: exchange is correct in every mode; with cpha=1 the MSB appears only after the first SCLK edge.
- Two-byte burst without reading RX and without refilling TX: second TX byte is `8'h00`, `tx_udr = 1`, `rx_ovr = 1`, `rx_data` = second byte. A write to 11 clears both flags.
- SS_N deasserted after 4 bits, then a full byte `8'hC3` is sent: `rx_data = 8'hC3`, no stale bits, `rx_valid` set exactly once.
- RX pop in the same clk as 8th-sample detection: `rx_valid` stays 1, `rx_ovr` stays 0.
- Reset asserted mid-byte: all outputs go to reset values immediately; the next full transfer is received correctly.
